// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package mc_ctrl_pkg;

  localparam int unsigned OP_W     = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned ALUCTL_W = 3;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  localparam logic [SEL_W-1:0] ALUOP_ADD  = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB  = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNC = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

  function automatic logic is_supported(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
interface mc_controller_if;
  import mc_ctrl_pkg::*;

  logic [OP_W-1:0]     op;
  logic [F3_W-1:0]     funct3;
  logic                funct7b5;
  logic                Zero;
  logic                PCWrite;
  logic                AdrSrc;
  logic                MemWrite;
  logic                IRWrite;
  logic [SEL_W-1:0]    ResultSrc;
  logic [SEL_W-1:0]    ALUSrcA;
  logic [SEL_W-1:0]    ALUSrcB;
  logic [SEL_W-1:0]    ImmSrc;
  logic                RegWrite;
  logic [ALUCTL_W-1:0] ALUControl;
  logic                Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, ALUControl, Illegal
  );
endinterface

// File: rtl/aludec.sv
// ALU decoder: maps ALUOp plus instruction fields to the ALU operation.
module aludec
  import mc_ctrl_pkg::*;
(
  input  logic                opb5,
  input  logic [F3_W-1:0]     funct3,
  input  logic                funct7b5,
  input  logic [SEL_W-1:0]    ALUOp,
  output logic [ALUCTL_W-1:0] ALUControl
);

  logic r_sub;
  assign r_sub = funct7b5 & opb5;

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = r_sub ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_immdec.sv
// Immediate format select decoded directly from the opcode.
module mc_immdec
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle RV32I core.
// Define MCCTRL_BNE_EN to let the branch state also execute bne (funct3=001).
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  state_t state_q, state_d, cur_state;

  logic [SEL_W-1:0]    alu_op;
  logic [SEL_W-1:0]    result_src, alu_src_a, alu_src_b, imm_src;
  logic [ALUCTL_W-1:0] alu_control;
  logic                pc_update, branch, branch_cond;
  logic                pc_write, adr_src, mem_write, ir_write, reg_write, illegal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // During reset the outputs show FETCH values with every write enable held low.
  assign cur_state = reset ? FETCH : state_q;

`ifdef MCCTRL_BNE_EN
  assign branch_cond = (bus.funct3 == 3'b001) ? ~bus.Zero : bus.Zero;
`else
  assign branch_cond = bus.Zero;
`endif

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (cur_state)
      FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        illegal   = ~is_supported(bus.op);
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNC;
      end
      EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNC;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    pc_write = (pc_update | (branch & branch_cond)) & ~reset;
    ir_write  = ir_write  & ~reset;
    mem_write = mem_write & ~reset;
    reg_write = reg_write & ~reset;
  end

  aludec u_aludec (
    .opb5       (bus.op[5]),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .ALUOp      (alu_op),
    .ALUControl (alu_control)
  );

  mc_immdec u_immdec (
    .op      (bus.op),
    .imm_src (imm_src)
  );

  assign bus.PCWrite    = pc_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUControl = alu_control;
  assign bus.Illegal    = illegal;

endmodule

// File: tb/tb_mc_controller.sv
// Directed plus random instruction bench for mc_controller, checked against a
// per-instruction timeline model.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

  logic [16:0] obs;
  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUControl,
                bus.Illegal};

  function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic memw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic rw,
                                     input logic [2:0] alu, input logic ill);
    return {pcw, adr, memw, irw, rs, sa, sb, imm, rw, alu, ill};
  endfunction

  function automatic int cls_of(input logic [6:0] op);
    int c;
    case (op)
      LW: c = C_LW;   SW: c = C_SW;   RT: c = C_R;
      IT: c = C_I;    BR: c = C_BEQ;  JL: c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] op_of(input int c);
    logic [6:0] o;
    case (c)
      C_LW: o = LW;  C_SW: o = SW;  C_R: o = RT;
      C_I:  o = IT;  C_BEQ: o = BR; C_JAL: o = JL;
      default: begin
        o = 7'($urandom);
        while (cls_of(o) != C_ILL) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  function automatic int n_cycles(input logic [6:0] op);
    int lens [7] = '{5, 4, 4, 4, 3, 4, 2};
    return lens[cls_of(op)];
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BR) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU operation requested by an R/I instruction, by funct3 meaning.
  function automatic logic [2:0] func_alu(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7);
    case (f3)
      3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z);
`ifdef MCCTRL_BNE_EN
    if (f3 == 3'b001) return ~z;
`endif
    return z;
  endfunction

  function automatic logic [16:0] reset_vec(input logic [6:0] op);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm_of(op), 1'b0, 3'b000, 1'b0);
  endfunction

  // Expected outputs for cycle k of an instruction, counted from its fetch.
  function automatic logic [16:0] expect_cycle(input logic [6:0] op, input logic [2:0] f3,
                                               input logic f7, input logic z, input int k);
    int          c;
    logic [1:0]  im;
    logic [16:0] e;
    logic [16:0] wb;
    c  = cls_of(op);
    im = imm_of(op);
    wb = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 1'b1, 3'b000, 1'b0);
    e  = '0;
    if (k == 0)
      e = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, im, 1'b0, 3'b000, 1'b0);
    else if (k == 1)
      e = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, im, 1'b0, 3'b000, c == C_ILL);
    else if (k == 2) begin
      case (c)
        C_LW, C_SW: e = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, im, 1'b0, 3'b000, 1'b0);
        C_R:   e = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, im, 1'b0, func_alu(op, f3, f7), 1'b0);
        C_I:   e = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, im, 1'b0, func_alu(op, f3, f7), 1'b0);
        C_BEQ: e = mk(taken(f3, z), 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, im, 1'b0, 3'b001, 1'b0);
        C_JAL: e = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, im, 1'b0, 3'b000, 1'b0);
        default: e = '0;
      endcase
    end else if (k == 3) begin
      case (c)
        C_LW:  e = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 1'b0, 3'b000, 1'b0);
        C_SW:  e = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, im, 1'b0, 3'b000, 1'b0);
        default: e = wb;
      endcase
    end else
      e = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, im, 1'b1, 3'b000, 1'b0);
    return e;
  endfunction

  task automatic check(input logic [16:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1; zmode <0 randomizes Zero every cycle.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zmode, input int abort_at, input string name);
    logic z;
    int   n;
    n = n_cycles(op);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    for (int k = 0; k < n; k++) begin
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.Zero = z;
      if (k == abort_at) begin
        reset = 1'b1;
        #3;
        check(reset_vec(op), $sformatf("%s_abort_c%0d", name, k));
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      #3;
      check(expect_cycle(op, f3, f7, z, k), $sformatf("%s_c%0d", name, k));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int         c;
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] f3_ri [4] = '{3'b000, 3'b010, 3'b110, 3'b111};

    reset        = 1'b1;
    bus.op       = LW;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check(reset_vec(LW), $sformatf("reset_c%0d", i));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    run_instr(LW, 3'b010, 1'b0, -1, -1, "lw");
    run_instr(SW, 3'b010, 1'b0, -1, -1, "sw");
    run_instr(RT, 3'b000, 1'b1, -1, -1, "sub");
    run_instr(IT, 3'b000, 1'b1, -1, -1, "addi_f7");
    run_instr(RT, 3'b111, 1'b0, -1, -1, "and");
    run_instr(BR, 3'b000, 1'b0, 1, -1, "beq_z1");
    run_instr(BR, 3'b000, 1'b0, 0, -1, "beq_z0");
    run_instr(BR, 3'b001, 1'b0, 1, -1, "bne_z1");
    run_instr(BR, 3'b001, 1'b0, 0, -1, "bne_z0");
    run_instr(7'b1111111, 3'b000, 1'b0, -1, -1, "illegal");
    run_instr(JL, 3'b000, 1'b0, -1, -1, "jal");
    run_instr(SW, 3'b000, 1'b0, -1, 3, "sw_rst");
    run_instr(LW, 3'b000, 1'b0, -1, -1, "lw_after_rst");
    run_instr(LW, 3'b000, 1'b0, -1, 1, "lw_rst_dec");
    run_instr(IT, 3'b110, 1'b0, -1, -1, "ori_after_rst");

    for (int i = 0; i < 300; i++) begin
      c  = int'($urandom_range(0, 6));
      op = op_of(c);
      f3 = 3'($urandom);
      if (c == C_R || c == C_I) f3 = f3_ri[$urandom_range(0, 3)];
      if (c == C_BEQ)           f3 = {2'b00, 1'($urandom_range(0, 1))};
      run_instr(op, f3, 1'($urandom_range(0, 1)), -1,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1,
                $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
